// File: rtl/sobel_frame_feeder_if.sv
// Pixel-in / row-out bundle for sobel_frame_feeder.
//   master : pixel source and array-side observer (drives pix_in/pix_valid/pix_sof)
//   slave  : the feeder itself (drives pix_ready, row_out, row_valid,
//            result_valid, result_row, busy)
// row_out slot s occupies bits [8s+7:8s]; there are COLS+2 slots per row.
interface sobel_frame_feeder_if #(
    parameter int COLS = 8,
    parameter int ROWS = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [7:0]              pix_in;
    logic                    pix_valid;
    logic                    pix_sof;
    logic                    pix_ready;
    logic [(COLS+2)*8-1:0]   row_out;
    logic                    row_valid;
    logic                    result_valid;
    logic [RW-1:0]           result_row;
    logic                    busy;

    modport master (
        output pix_in, pix_valid, pix_sof,
        input  pix_ready, row_out, row_valid, result_valid, result_row, busy
    );

    modport slave (
        input  pix_in, pix_valid, pix_sof,
        output pix_ready, row_out, row_valid, result_valid, result_row, busy
    );
endinterface

// File: rtl/sobel_frame_feeder.sv
// sobel_frame_feeder: collects one ROWS x COLS frame from a raster pixel
// stream, then bursts it out one edge-padded row per clock (ROWS+2 rows,
// first and last rows replicated) for the column-parallel sobel array.
// A SOBEL_LAT-deep tag line marks the array output cycles that carry a
// valid centre-row result.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of sobel_frame_feeder_if (pixel handshake in,
//            padded rows / result tag / busy out)
module sobel_frame_feeder #(
    parameter int COLS      = 8,
    parameter int ROWS      = 8,
    parameter int SOBEL_LAT = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sobel_frame_feeder_if.slave  bus
);
    localparam int NPIX = ROWS * COLS;
    localparam int AW   = $clog2(NPIX + 1);
    localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CW   = $clog2(ROWS + 2);
    localparam int DW   = (SOBEL_LAT > 1) ? $clog2(SOBEL_LAT) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {LOAD, BURST, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   pos_q, pos_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            pix_ready_q, row_valid_q, busy_q;

    logic [7:0]      mem_q [NPIX];

    logic            accept;
    logic [AW-1:0]   wr_addr;

    // pix_ready_q is only ever high in LOAD, so accepts only happen there.
    assign accept  = bus.pix_valid & pix_ready_q;
    // A start-of-frame pixel always lands at address 0, dropping any partial frame.
    assign wr_addr = bus.pix_sof ? '0 : wr_ptr_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        pos_d    = pos_q;
        drain_d  = drain_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (wr_addr == AW'(NPIX - 1)) begin
                        state_d  = BURST;
                        wr_ptr_d = '0;
                        pos_d    = '0;
                    end else begin
                        wr_ptr_d = wr_addr + 1'b1;
                    end
                end
            end
            BURST: begin
                if (pos_q == CW'(ROWS + 1)) begin
                    state_d = DRAIN;
                    pos_d   = '0;
                    drain_d = '0;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DW'(SOBEL_LAT - 1)) begin
                    state_d = LOAD;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            wr_ptr_q    <= '0;
            pos_q       <= '0;
            drain_q     <= '0;
            pix_ready_q <= 1'b0;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            pos_q       <= pos_d;
            drain_q     <= drain_d;
            pix_ready_q <= (state_d == LOAD);
            row_valid_q <= (state_d == BURST);
            busy_q      <= (state_d != LOAD);
        end
    end

    // Frame store: written only on accepts, never reset (contents are
    // meaningless until a full frame has been loaded).
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_addr[IW-1:0]] <= bus.pix_in;
        end
    end

    // Source row for burst position p: max(p-1,0) clipped to ROWS-1.
    logic [CW-1:0] src_row;
    always_comb begin
        src_row = '0;
        if (pos_q == '0) begin
            src_row = '0;
        end else if (pos_q > CW'(ROWS)) begin
            src_row = CW'(ROWS - 1);
        end else begin
            src_row = pos_q - 1'b1;
        end
    end

    logic [IW-1:0]         row_base;
    logic [7:0]            row_pix [COLS];
    logic [(COLS+2)*8-1:0] row_data;

    assign row_base = IW'(src_row) * IW'(COLS);

    // Slot c+1 carries column c; slots 0 and COLS+1 replicate the edge columns.
    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            assign row_pix[gi]              = mem_q[row_base + IW'(gi)];
            assign row_data[8*(gi+1) +: 8]  = row_pix[gi];
        end
    endgenerate
    assign row_data[7:0]             = row_pix[0];
    assign row_data[8*(COLS+1) +: 8] = row_pix[COLS-1];

    // Centre-row tag: position p >= 2 completes the window for row p-2.
    logic            tag_in_valid;
    logic [RW-1:0]   tag_in_row;
    logic [SOBEL_LAT-1:0] tag_valid_q;
    logic [RW-1:0]   tag_row_q [SOBEL_LAT];

    assign tag_in_valid = (state_q == BURST) && (pos_q >= CW'(2));
    assign tag_in_row   = tag_in_valid ? RW'(pos_q - CW'(2)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_q <= '0;
            for (int i = 0; i < SOBEL_LAT; i++) begin
                tag_row_q[i] <= '0;
            end
        end else begin
            tag_valid_q[0] <= tag_in_valid;
            tag_row_q[0]   <= tag_in_row;
            for (int i = 1; i < SOBEL_LAT; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_row_q[i]   <= tag_row_q[i-1];
            end
        end
    end

    assign bus.pix_ready    = pix_ready_q;
    assign bus.row_valid    = row_valid_q;
    assign bus.row_out      = row_valid_q ? row_data : '0;
    assign bus.busy         = busy_q;
    assign bus.result_valid = tag_valid_q[SOBEL_LAT-1];
    assign bus.result_row   = tag_row_q[SOBEL_LAT-1];
endmodule

// File: doc/sobel_frame_feeder.md
Name: sobel_frame_feeder

Overview:
- Upstream stage of the column-parallel sobel array. Each array element is one sequential_sobel instance per image column.
- Accepts a raster pixel stream through a valid/ready handshake and stores one ROWS x COLS frame.
- Bursts the frame out one full padded row per clock, back to back, which the free-running array needs.
- Produces a delayed tag, result_valid/result_row, that marks which array output cycles carry a valid centre-row result.

Parameters:
- COLS, 8, image width; equals the number of sobel elements.
- ROWS, 8, image height.
- SOBEL_LAT, 5, clocks from a row on row_out to the matching sobel_out of the array; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- pix_in  input  8  raster pixel, row-major, column 0 first.
- pix_valid  input  1  pix_in valid.
- pix_sof  input  1  first pixel of frame; sampled with pix_valid.
- pix_ready  output  1  feeder accepts a pixel this cycle.
- row_out  output  (COLS+2)*8  padded row. Slot s is bits [8s+7:8s]. Element i takes left=slot i, current=slot i+1, right=slot i+2.
- row_valid  output  1  row_out carries a burst row.
- result_valid  output  1  array sobel_out is a valid centre-row result this cycle.
- result_row  output  clog2(ROWS)  centre row index of that result.
- busy  output  1  high in BURST or DRAIN.

Behaviour:
- Reset values, all registered outputs: pix_ready=0, row_out=0, row_valid=0, result_valid=0, result_row=0, busy=0. Write pointer, burst counter and delay line are cleared; state=LOAD.
- pix_ready goes to 1 on the first clock after reset release.
- Frame store: ROWS*COLS x 8 bits, register array.
- Accept condition: pix_valid & pix_ready. Each accept writes pix_in at the write pointer, then increments it.
- Accept with pix_sof=1 writes at address 0 and sets the pointer to 1, discarding any partial frame.
- States:
  - LOAD: pix_ready=1. The accept that writes address ROWS*COLS-1 moves to BURST next clock and clears pix_ready the same edge.
  - BURST: pix_ready=0, busy=1. Runs exactly ROWS+2 consecutive cycles, burst position p=0..ROWS+1, with row_valid=1 throughout. Source row = max(p-1,0) clipped to ROWS-1, so the sequence is row 0, row 0, row 1, ..., row ROWS-1, row ROWS-1 (edge replication vertically). After p=ROWS+1, go to DRAIN.
  - DRAIN: row_valid=0, row_out=0, busy=1. Holds SOBEL_LAT cycles, then returns to LOAD with pix_ready=1.
- Padding: slot c+1 = pixel column c; slot 0 = column 0; slot COLS+1 = column COLS-1 (edge replication horizontally).
- row_out is forced to 0 whenever row_valid=0.
- Centre tag: position p in 2..ROWS+1 is a complete window for centre row p-2. The tag {1, p-2} enters a SOBEL_LAT-deep shift register. Its output drives result_valid and result_row. With valid=0 the row field is 0.
- Per frame: exactly ROWS result_valid pulses, contiguous, result_row 0..ROWS-1 in order.
- Latency: first row_valid is 1 clock after the final accept. First result_valid is 2+SOBEL_LAT clocks after the first row_valid.
- pix_sof or pix_valid during BURST/DRAIN is ignored (not accepted), since pix_ready=0.
- Reset asserted mid-operation clears everything immediately (async); no partial burst resumes.
- Width rules: write pointer clog2(ROWS*COLS+1) bits; burst counter clog2(ROWS+2) bits; no wrap within a frame.

Test Plan:
- Reset/idle: rst_n=0 then 1 -> all outputs 0 during reset; pix_ready=1 the next clock; row_valid stays 0 with no input.
- Ramp frame, COLS=8, ROWS=8, pixel = 8*r+c, pix_valid held 1, pix_sof on first -> 64 accepts; then 10 row_valid cycles. First row_out slots = 0,0,1,...,7,7; second identical; tenth slots = 56,56,...,63,63.
- Result tagging, SOBEL_LAT=5 -> result_valid high 8 consecutive cycles, starting 7 clocks after the first row_valid; result_row 0..7; pix_ready returns 1 after DRAIN.
- Backpressure/gaps: pix_valid toggled randomly; extra pixels driven during BURST -> only pixels with pix_ready=1 stored; burst content matches the scoreboard.
- Resync: 20 pixels, then pix_sof with a fresh 64-pixel frame -> burst contains only the new frame.
- Reset mid-BURST at position 4 -> row_valid, result_valid and busy drop to 0 asynchronously. A subsequent full frame bursts correctly from row 0.
